// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the SAP-1 hardwired sequencer: opcodes, control-bit indices, FSM states.
package control_sequencer_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam int unsigned CTL_HLT = 15;
  localparam int unsigned CTL_MI  = 14;
  localparam int unsigned CTL_RI  = 13;
  localparam int unsigned CTL_RO  = 12;
  localparam int unsigned CTL_IO  = 11;
  localparam int unsigned CTL_II  = 10;
  localparam int unsigned CTL_AI  = 9;
  localparam int unsigned CTL_AO  = 8;
  localparam int unsigned CTL_EO  = 7;
  localparam int unsigned CTL_SU  = 6;
  localparam int unsigned CTL_BI  = 5;
  localparam int unsigned CTL_OI  = 4;
  localparam int unsigned CTL_CE  = 3;
  localparam int unsigned CTL_CO  = 2;
  localparam int unsigned CTL_J   = 1;
  localparam int unsigned CTL_FI  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } state_t;

  function automatic logic [15:0] ctl(input int unsigned b);
    return 16'd1 << b;
  endfunction

endpackage

// File: rtl/control_sequencer_ctrl_decode.sv
// Combinational step/opcode/flags -> control word decode, plus end-of-instruction flag.
// CTRL_SEQ_EARLY_END_EN: instructions end at their last non-zero step instead of MAX_STEPS-1.
module ctrl_decode
  import control_sequencer_pkg::*;
#(
  parameter int unsigned MAX_STEPS = 5
) (
  input  logic [2:0]  step,
  input  logic [3:0]  opcode,
  input  logic        flag_c,
  input  logic        flag_z,
  output logic [15:0] word,
  output logic        last
);

  logic [15:0] w2, w3, w4;

  always_comb begin
    w2 = '0;
    w3 = '0;
    w4 = '0;
    case (opcode)
      OP_LDA: begin
        w2 = ctl(CTL_IO) | ctl(CTL_MI);
        w3 = ctl(CTL_RO) | ctl(CTL_AI);
      end
      OP_ADD, OP_SUB: begin
        w2 = ctl(CTL_IO) | ctl(CTL_MI);
        w3 = ctl(CTL_RO) | ctl(CTL_BI);
        w4 = ctl(CTL_EO) | ctl(CTL_AI) | ctl(CTL_FI) | ((opcode == OP_SUB) ? ctl(CTL_SU) : '0);
      end
      OP_STA: begin
        w2 = ctl(CTL_IO) | ctl(CTL_MI);
        w3 = ctl(CTL_AO) | ctl(CTL_RI);
      end
      OP_LDI: w2 = ctl(CTL_IO) | ctl(CTL_AI);
      OP_JMP: w2 = ctl(CTL_IO) | ctl(CTL_J);
      OP_JC:  w2 = flag_c ? (ctl(CTL_IO) | ctl(CTL_J)) : '0;
      OP_JZ:  w2 = flag_z ? (ctl(CTL_IO) | ctl(CTL_J)) : '0;
      OP_OUT: w2 = ctl(CTL_AO) | ctl(CTL_OI);
      OP_HLT: w2 = ctl(CTL_HLT);
      default: ;
    endcase
  end

  always_comb begin
    word = '0;
    case (step)
      3'd0: word = ctl(CTL_CO) | ctl(CTL_MI);
      3'd1: word = ctl(CTL_RO) | ctl(CTL_II) | ctl(CTL_CE);
      3'd2: word = w2;
      3'd3: word = w3;
      3'd4: word = w4;
      default: word = '0;
    endcase
  end

`ifdef CTRL_SEQ_EARLY_END_EN
  logic [2:0] end_step;

  always_comb begin
    end_step = 3'd1;
    case (opcode)
      OP_LDA, OP_STA:                 end_step = 3'd3;
      OP_ADD, OP_SUB:                 end_step = 3'd4;
      OP_LDI, OP_JMP, OP_OUT, OP_HLT: end_step = 3'd2;
      OP_JC:                          end_step = flag_c ? 3'd2 : 3'd1;
      OP_JZ:                          end_step = flag_z ? 3'd2 : 3'd1;
      default:                        end_step = 3'd1;
    endcase
  end

  // A short MAX_STEPS truncates long instructions at the final step.
  assign last = (step >= end_step) || (step == 3'(MAX_STEPS - 1));
`else
  assign last = (step == 3'(MAX_STEPS - 1));
`endif

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 hardwired control sequencer: run/pause/single-step/halt FSM with registered control outputs.
// Optional CTRL_SEQ_EARLY_END_EN shortens instructions to their last non-zero step.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int unsigned MAX_STEPS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opcode,
  input  logic        flag_c,
  input  logic        flag_z,
  input  logic        run,
  input  logic        step_req,
  output logic [15:0] ctrl,
  output logic [2:0]  t_state,
  output logic        halted,
  output logic        instr_done
);

  state_t      state_q, state_d;
  logic        single_q, single_d;
  logic [2:0]  step_d;
  logic        load;
  logic [15:0] dec_word;
  logic        dec_last;

  ctrl_decode #(.MAX_STEPS(MAX_STEPS)) u_decode (
    .step   (step_d),
    .opcode (opcode),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .word   (dec_word),
    .last   (dec_last)
  );

  // instr_done and ctrl[hlt] are registered views of the step now being presented.
  always_comb begin
    state_d  = state_q;
    single_d = single_q;
    step_d   = t_state;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        step_d = 3'd0;
        if (run) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end else if (step_req) begin
          state_d  = ST_RUN;
          single_d = 1'b1;
          load     = 1'b1;
        end
      end
      ST_RUN: begin
        if (ctrl[CTL_HLT]) begin
          state_d = ST_HALT;
        end else if (instr_done) begin
          step_d = 3'd0;
          if (single_q || !run) begin
            state_d  = ST_IDLE;
            single_d = 1'b0;
          end else begin
            load = 1'b1;
          end
        end else begin
          step_d = t_state + 3'd1;
          load   = 1'b1;
        end
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      single_q   <= 1'b0;
      ctrl       <= '0;
      t_state    <= '0;
      halted     <= 1'b0;
      instr_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      single_q   <= single_d;
      ctrl       <= load ? dec_word : '0;
      t_state    <= step_d;
      halted     <= (state_d == ST_HALT);
      instr_done <= load & dec_last;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed plus randomized bench for control_sequencer against a table-driven instruction model.
module tb_control_sequencer;

  localparam int MAX_STEPS = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic        flag_c;
  logic        flag_z;
  logic        run;
  logic        step_req;
  logic [15:0] ctrl;
  logic [2:0]  t_state;
  logic        halted;
  logic        instr_done;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] tbl [16][MAX_STEPS];

  control_sequencer #(.MAX_STEPS(MAX_STEPS)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .run        (run),
    .step_req   (step_req),
    .ctrl       (ctrl),
    .t_state    (t_state),
    .halted     (halted),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] ec, input logic [2:0] et,
                       input logic ed, input logic eh);
    vectors++;
    assert ({ctrl, t_state, instr_done, halted} === {ec, et, ed, eh}) else begin
      miscompares++;
      $error("FAIL %s: got ctrl=%h t_state=%0d done=%b halted=%b, want ctrl=%h t_state=%0d done=%b halted=%b",
             tag, ctrl, t_state, instr_done, halted, ec, et, ed, eh);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [15:0] exp_word(input int op, input int k, input logic c, input logic z);
    if (k == 2 && ((op == 7 && !c) || (op == 8 && !z))) return 16'h0000;
    return tbl[op][k];
  endfunction

  function automatic int exp_len(input int op, input logic c, input logic z);
`ifdef CTRL_SEQ_EARLY_END_EN
    int n = 0;
    for (int k = 0; k < MAX_STEPS; k++)
      if (exp_word(op, k, c, z) != 16'h0000) n = k + 1;
    return n;
`else
    return MAX_STEPS;
`endif
  endfunction

  // One whole instruction; HLT additionally checks entry into the halted state.
  task automatic do_instr(input int op, input logic c, input logic z, input bit pulse, input string tag);
    int n;
    int stop;
    opcode = 4'(op);
    flag_c = c;
    flag_z = z;
    if (pulse) step_req = 1'b1;
    n    = exp_len(op, c, z);
    stop = (op == 15) ? 3 : n;
    for (int k = 0; k < stop; k++) begin
      tick();
      step_req = 1'b0;
      check(tag, exp_word(op, k, c, z), 3'(k), (k == n - 1), 1'b0);
    end
    if (op == 15) begin
      tick();
      check({tag, "_halt"}, 16'h0000, 3'd2, 1'b0, 1'b1);
    end
  endtask

  initial begin
    for (int o = 0; o < 16; o++)
      for (int k = 0; k < MAX_STEPS; k++)
        tbl[o][k] = 16'h0000;
    for (int o = 0; o < 16; o++) begin
      tbl[o][0] = 16'h4004;
      tbl[o][1] = 16'h1408;
    end
    tbl[1][2]  = 16'h4800; tbl[1][3] = 16'h1200;
    tbl[2][2]  = 16'h4800; tbl[2][3] = 16'h1020; tbl[2][4] = 16'h0281;
    tbl[3][2]  = 16'h4800; tbl[3][3] = 16'h1020; tbl[3][4] = 16'h02C1;
    tbl[4][2]  = 16'h4800; tbl[4][3] = 16'h2100;
    tbl[5][2]  = 16'h0A00;
    tbl[6][2]  = 16'h0802;
    tbl[7][2]  = 16'h0802;
    tbl[8][2]  = 16'h0802;
    tbl[14][2] = 16'h0110;
    tbl[15][2] = 16'h8000;

    reset    = 1'b0;
    run      = 1'b1;
    step_req = 1'b0;
    opcode   = 4'd1;
    flag_c   = 1'b0;
    flag_z   = 1'b0;
    #3;
    check("reset", 16'h0000, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    do_instr(1, 1'b0, 1'b0, 1'b0, "lda");
    do_instr(2, 1'b0, 1'b0, 1'b0, "add");
    do_instr(3, 1'b0, 1'b0, 1'b0, "sub");
    do_instr(7, 1'b1, 1'b0, 1'b0, "jc_taken");
    do_instr(7, 1'b0, 1'b1, 1'b0, "jc_not");
    do_instr(8, 1'b0, 1'b1, 1'b0, "jz_taken");
    do_instr(8, 1'b1, 1'b0, 1'b0, "jz_not");
    do_instr(4, 1'b0, 1'b0, 1'b0, "sta");
    do_instr(5, 1'b0, 1'b0, 1'b0, "ldi");
    do_instr(6, 1'b0, 1'b0, 1'b0, "jmp");
    do_instr(14, 1'b0, 1'b0, 1'b0, "out");
    do_instr(0, 1'b0, 1'b0, 1'b0, "nop");
    do_instr(11, 1'b1, 1'b1, 1'b0, "op11");

    repeat (40) begin
      do_instr(int'($urandom_range(0, 14)), 1'($urandom), 1'($urandom), 1'b0, "rand");
    end

    // Asynchronous reset in the middle of ADD T3.
    opcode = 4'd2;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("add_pre_reset", tbl[2][k], 3'(k), 1'b0, 1'b0);
    end
    #2 reset = 1'b0;
    #1 check("async_reset", 16'h0000, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    do_instr(1, 1'b0, 1'b0, 1'b0, "after_reset");

    // Paused operation with single-instruction stepping.
    run   = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      tick();
      check("paused_idle", 16'h0000, 3'd0, 1'b0, 1'b0);
    end
    do_instr(14, 1'b0, 1'b0, 1'b1, "single1");
    repeat (3) begin
      tick();
      check("single1_idle", 16'h0000, 3'd0, 1'b0, 1'b0);
    end
    do_instr(14, 1'b0, 1'b0, 1'b1, "single2");
    repeat (3) begin
      tick();
      check("single2_idle", 16'h0000, 3'd0, 1'b0, 1'b0);
    end

    // Halt is sticky until reset.
    run = 1'b1;
    do_instr(15, 1'b0, 1'b0, 1'b0, "hlt");
    repeat (20) begin
      run      = 1'($urandom);
      step_req = 1'($urandom);
      tick();
      check("halt_hold", 16'h0000, 3'd2, 1'b0, 1'b1);
    end
    step_req = 1'b0;
    reset    = 1'b0;
    #1 check("halt_reset", 16'h0000, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b1;
    do_instr(5, 1'b0, 1'b0, 1'b0, "post_halt");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
